// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler that shares one bit-serial comparator between two
// parallel-word requesters: latch operands, clear comparator, shift MSB-first,
// capture E/L/G, then pulse done to the served requester.
module serial_compare_scheduler #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             done0,
  output logic             done1,
  output logic             res_e,
  output logic             res_l,
  output logic             res_g,
  output logic             res_err,
  output logic             busy,
  output logic             grant,
  output logic             cmp_rst,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_e,
  input  logic             cmp_l,
  input  logic             cmp_g
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ptr_q, ptr_d;

  logic grant_d, done0_d, done1_d;
  logic res_e_d, res_l_d, res_g_d, res_err_d;
  logic busy_d, cmp_rst_d, cmp_x_d, cmp_y_d;
  logic win_c, onehot_c;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    res_e_d   = res_e;
    res_l_d   = res_l;
    res_g_d   = res_g;
    res_err_d = res_err;
    cmp_x_d   = 1'b0;
    cmp_y_d   = 1'b0;

    // Pointer names the tie winner; a lone requester always wins
    win_c    = (req0 && req1) ? ptr_q : req1;
    onehot_c = (cmp_e & ~cmp_l & ~cmp_g) |
               (~cmp_e & cmp_l & ~cmp_g) |
               (~cmp_e & ~cmp_l & cmp_g);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = CLR;
          grant_d = win_c;
          xs_d    = win_c ? x1 : x0;
          ys_d    = win_c ? y1 : y0;
        end
      end
      CLR: begin
        state_d = SHIFT;
        cnt_d   = CW'(WIDTH - 1);
        cmp_x_d = xs_q[WIDTH-1];
        cmp_y_d = ys_q[WIDTH-1];
        xs_d    = xs_q << 1;
        ys_d    = ys_q << 1;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = CAPT;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          cmp_x_d = xs_q[WIDTH-1];
          cmp_y_d = ys_q[WIDTH-1];
          xs_d    = xs_q << 1;
          ys_d    = ys_q << 1;
        end
      end
      CAPT: begin
        state_d   = DONE;
        res_e_d   = cmp_e;
        res_l_d   = cmp_l;
        res_g_d   = cmp_g;
        res_err_d = ~onehot_c;
        done0_d   = ~grant;
        done1_d   = grant;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~grant;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs registered alongside the state they belong to
    busy_d    = (state_d != IDLE);
    cmp_rst_d = (state_d == IDLE) || (state_d == CLR) || (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      grant   <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res_e   <= 1'b0;
      res_l   <= 1'b0;
      res_g   <= 1'b0;
      res_err <= 1'b0;
      busy    <= 1'b0;
      cmp_rst <= 1'b1;
      cmp_x   <= 1'b0;
      cmp_y   <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      done0   <= done0_d;
      done1   <= done1_d;
      res_e   <= res_e_d;
      res_l   <= res_l_d;
      res_g   <= res_g_d;
      res_err <= res_err_d;
      busy    <= busy_d;
      cmp_rst <= cmp_rst_d;
      cmp_x   <= cmp_x_d;
      cmp_y   <= cmp_y_d;
    end
  end

endmodule

// File: doc/serial_compare_scheduler.md
Name: serial_compare_scheduler

Overview:
- Shares one `serial_comparator` instance between two requesters using round-robin arbitration.
- Latches the granted requester's parallel WIDTH-bit operand pair and clears the comparator for one cycle.
- Shifts the operands into the comparator MSB-first, one bit per clock, then captures E/L/G.
- Returns the result to the granted requester with a one-cycle done pulse. Sits between parallel-word clients and the bit-serial comparator.

Parameters:
- WIDTH, 5: operand width in bits; also the number of shift cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req0  in  1  requester 0 request (level)
- x0  in  WIDTH  requester 0 operand X
- y0  in  WIDTH  requester 0 operand Y
- req1  in  1  requester 1 request (level)
- x1  in  WIDTH  requester 1 operand X
- y1  in  WIDTH  requester 1 operand Y
- done0  out  1  one-cycle pulse: result for requester 0 valid
- done1  out  1  one-cycle pulse: result for requester 1 valid
- res_e, res_l, res_g  out  1 each  captured comparator flags (X==Y, X<Y, X>Y)
- res_err  out  1  captured flags not exactly one-hot
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the requester currently being served
- cmp_rst  out  1  comparator reset, active-high
- cmp_x, cmp_y  out  1 each  serial operand bits to comparator
- cmp_e, cmp_l, cmp_g  in  1 each  comparator E/L/G outputs

Behaviour:
- All outputs are registered.
- Reset values while reset=0: state=IDLE, cmp_rst=1, cmp_x=cmp_y=0, done0=done1=0, res_*=0, res_err=0, busy=0, grant=0, priority pointer=0.
- FSM states: IDLE, CLR, SHIFT, CAPT, DONE.
- IDLE: cmp_rst=1.
  - If any req is high, grant per pointer. Pointer=p means requester p wins a tie; a lone requester always wins.
  - On grant: latch x/y of the winner into internal shift registers, set grant, go to CLR.
  - Requester operands may change after the grant cycle.
- CLR: cmp_rst=1 for exactly one cycle; load bit counter = WIDTH-1; go to SHIFT.
- SHIFT: cmp_rst=0; cmp_x/cmp_y = bit[counter] of the latched X/Y, MSB first.
  - Stays exactly WIDTH cycles; counter decrements.
  - Leaves to CAPT after the cycle presenting bit 0.
- CAPT: cmp_rst=0; cmp_x/cmp_y=0.
  - At the end of the cycle, register cmp_e/l/g into res_e/l/g.
  - res_err = !(exactly one of the three flags set).
  - Go to DONE.
- DONE: done[grant]=1 for one cycle; cmp_rst=1; pointer = ~grant; go to IDLE.
- res_* and res_err hold their value until the next CAPT.
- Latency from the grant edge to done: 1 (CLR) + WIDTH (SHIFT) + 1 (CAPT) + 1 (DONE) cycles.
  - For WIDTH=5, done is high in the 8th cycle after the cycle req was sampled.
- Request protocol:
  - req is level-sensitive. A requester must drop req in the cycle after done is seen.
  - A req still high in IDLE after DONE is a new request.
  - req changes during CLR/SHIFT/CAPT/DONE are ignored; no preemption.
- Simultaneous requests: served alternately (0,1,0,1...) when both are held continuously.
- Reset asserted mid-operation: abort at the next edge to reset values. No done pulse; the pending request is lost. Comparator is cleared via cmp_rst=1.
- WIDTH=1: SHIFT lasts one cycle; all other rules unchanged.

Test Plan:
1. WIDTH=5; req0 with x0=10110(22), y0=10011(19) -> cmp_x serial 1,0,1,1,0; done0 pulse 8 cycles later; res_g=1, res_e=res_l=0, res_err=0; done1 stays 0.
2. req1 with x1=01010(10), y1=01010(10) -> res_e=1, res_l=res_g=0; grant=1; done1 only.
3. req0 and req1 both raised in the same cycle after reset and held (x0=00001,y0=00010; x1=11111,y1=00000):
   - first done0 with res_l=1;
   - then done1 with res_g=1;
   - then done0 again.
   Checks alternation and the busy profile.
4. Reset mid-SHIFT (third shift cycle of a request) -> next cycle all outputs at reset values, cmp_rst=1, no done pulse. A new req0 with x0=00000,y0=11111 afterwards completes normally with res_l=1.
5. Comparator model forced to drive cmp_e=cmp_g=1 at CAPT -> res_err=1 alongside done. The next normal transaction clears res_err to 0.
6. Operand-latch check: change x0/y0 the cycle after grant (x0 11000→00000, y0 10000) -> result still res_g=1.
